vga_timing_generator: RTL and testbench
=======================================

# vga_timing_generator

Parametrised VGA raster timing generator for the graphics processing unit. Divides the system clock to a pixel rate and produces horizontal/vertical counters, screen coordinates, sync pulses of selectable polarity, blanking and frame/line markers. A configurable pipeline delay keeps sync and blank aligned with the pixel-fetch latency of the downstream colour path. It replaces the fixed 640x480 counters with one block that covers any mode through parameters.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel (≥1)
- HS_POL, 0, H_SYNC level during the sync pulse
- VS_POL, 0, V_SYNC level during the sync pulse
- PIPE_DELAY, 0, pixel ticks by which sync/blank lag the coordinates (0–7)
- CW, 10, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- CLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- EN  in  1  run enable; 0 freezes counters at their current values
- SCREEN_POS_X  out  CW  horizontal counter, 0..H_TOTAL-1
- SCREEN_POS_Y  out  CW  vertical counter, 0..V_TOTAL-1
- PIX_EN  out  1  one-CLK strobe per pixel tick
- ACTIVE  out  1  coordinates are inside the visible area (undelayed)
- H_SYNC  out  1  horizontal sync, delayed by PIPE_DELAY
- V_SYNC  out  1  vertical sync, delayed by PIPE_DELAY
- VGA_BLANK_N  out  1  high in the visible area, delayed by PIPE_DELAY
- VGA_SYNC_N  out  1  constant 0 (no sync-on-green)
- VGA_CLK  out  1  pixel clock; high for the first ceil(CLK_DIV/2) CLKs of each pixel period
- LINE_START  out  1  one-tick pulse with PIX_EN when X wraps to 0
- FRAME_START  out  1  one-tick pulse with PIX_EN when X and Y both wrap to 0

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Divider counter 0..CLK_DIV-1 advances each CLK while EN=1. PIX_EN=1 on the CLK where the divider is at CLK_DIV-1. CLK_DIV=1 gives PIX_EN=EN.
- On PIX_EN: X increments. At H_TOTAL-1, X wraps to 0 and Y increments. At V_TOTAL-1, Y wraps to 0.
- Horizontal regions: active 0..H_ACTIVE-1; front porch next; sync H_ACTIVE+H_FRONT..H_ACTIVE+H_FRONT+H_SYNC-1; back porch last. Vertical regions follow the same scheme on Y.
- ACTIVE = (X<H_ACTIVE)&&(Y<V_ACTIVE), combinational from the registered counters.
- Raw hsync, vsync and blank_n go through a PIPE_DELAY-stage shift register that advances only on PIX_EN. PIPE_DELAY=0 means direct registered output.
- EN=0: the divider, counters, VGA_CLK and the delay line hold. PIX_EN, LINE_START and FRAME_START are 0.
- Reset (RST=0, async): divider, X, Y = 0. Delay line is loaded with the inactive values: sync at !POL, blank_n=0. Outputs: H_SYNC=!HS_POL, V_SYNC=!VS_POL, VGA_BLANK_N=0, PIX_EN=0, VGA_CLK=0, LINE_START=0, FRAME_START=0, VGA_SYNC_N=0.
- Reset mid-frame aborts the frame. After release the block restarts at (0,0) on the first enabled pixel period.

## Timing
- All outputs are registered except ACTIVE, PIX_EN, LINE_START and FRAME_START, which are decoded from registers.
- The counters update on the CLK edge that ends a PIX_EN cycle.
- Sync/blank for coordinate (X,Y) appear PIPE_DELAY pixel ticks after that coordinate, plus one registering edge.
- First PIX_EN after reset release is on CLK number CLK_DIV (1-based), with EN held high.

## Structure
- Package gpu_video_pkg: timing-mode struct typedef (active/front/sync/back for h and v), localparams MODE_640X480 and MODE_800X600, and a function returning the total from a mode.
- Sub-module video_axis_counter (one axis: counter, wrap, region decode). Instantiated twice: horizontal steps on PIX_EN, vertical on the horizontal wrap.
- Top level holds the divider and the delay line.

## Test plan
- Reset with defaults, CLK_DIV=2 -> all outputs at reset values; first PIX_EN on the 2nd CLK after RST rises; X=1 after that edge.
- Small mode (H 4/1/2/1, V 3/1/1/1, CLK_DIV=1, PIPE_DELAY=0) -> H_SYNC low exactly for X=5,6; V_SYNC low for Y=4; VGA_BLANK_N high for 12 ticks per frame; FRAME_START every 48 ticks.
- Same mode with PIPE_DELAY=3 -> H_SYNC falling edge 3 ticks after X=5; ACTIVE unchanged.
- HS_POL=1, VS_POL=1 -> sync pulses are high, idle low, including in reset.
- EN deasserted at X=2,Y=1 for 10 CLKs -> counters and VGA_CLK hold, no PIX_EN; resumes at X=3.
- RST asserted at X=6,Y=4 -> immediately X=Y=0, syncs inactive, VGA_BLANK_N=0; clean frame follows.

Source files
------------

// File: rtl/gpu_video_pkg.sv
// Shared video timing types: per-axis porch/sync description, two standard modes
// and a helper that sums an axis into its total period.
package gpu_video_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] front;
        logic [15:0] sync;
        logic [15:0] back;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
    } timing_mode_t;

    localparam timing_mode_t MODE_640X480 = '{
        h: '{active: 16'd640, front: 16'd16, sync: 16'd96,  back: 16'd48},
        v: '{active: 16'd480, front: 16'd10, sync: 16'd2,   back: 16'd33}
    };

    localparam timing_mode_t MODE_800X600 = '{
        h: '{active: 16'd800, front: 16'd40, sync: 16'd128, back: 16'd88},
        v: '{active: 16'd600, front: 16'd1,  sync: 16'd4,   back: 16'd23}
    };

    function automatic int unsigned axis_total(input axis_timing_t a);
        return 32'(a.active) + 32'(a.front) + 32'(a.sync) + 32'(a.back);
    endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: position counter that wraps at the axis total, plus decode of
// the visible region and the sync region from the current position.
module video_axis_counter
    import gpu_video_pkg::*;
#(
    parameter int unsigned ACTIVE_LEN = 640,
    parameter int unsigned FRONT_LEN  = 16,
    parameter int unsigned SYNC_LEN   = 96,
    parameter int unsigned BACK_LEN   = 48,
    parameter int unsigned CW         = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step,
    output logic [CW-1:0] pos,
    output logic          wrap,
    output logic          active,
    output logic          in_sync
);

    localparam axis_timing_t TIMING = '{
        active: 16'(ACTIVE_LEN), front: 16'(FRONT_LEN),
        sync:   16'(SYNC_LEN),   back:  16'(BACK_LEN)
    };
    localparam int unsigned TOTAL      = axis_total(TIMING);
    localparam int unsigned SYNC_START = ACTIVE_LEN + FRONT_LEN;
    localparam int unsigned SYNC_END   = SYNC_START + SYNC_LEN;

    logic [CW-1:0] pos_q, pos_d;

    assign wrap = step && (32'(pos_q) == TOTAL - 1);

    always_comb begin
        pos_d = pos_q;
        if (step) begin
            pos_d = wrap ? '0 : pos_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    // Compare at 32 bits so a zero back porch cannot overflow the CW-wide bound.
    assign pos     = pos_q;
    assign active  = 32'(pos_q) < ACTIVE_LEN;
    assign in_sync = (32'(pos_q) >= SYNC_START) && (32'(pos_q) < SYNC_END);

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing: pixel-rate divider, H/V axis counters, and a pixel-tick delay
// line that keeps sync and blank aligned with the downstream colour fetch.
module vga_timing_generator
    import gpu_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC_LEN = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC_LEN = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned CLK_DIV    = 2,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int unsigned PIPE_DELAY = 0,
    parameter int unsigned CW         = 10
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    output logic [CW-1:0] SCREEN_POS_X,
    output logic [CW-1:0] SCREEN_POS_Y,
    output logic          PIX_EN,
    output logic          ACTIVE,
    output logic          H_SYNC,
    output logic          V_SYNC,
    output logic          VGA_BLANK_N,
    output logic          VGA_SYNC_N,
    output logic          VGA_CLK,
    output logic          LINE_START,
    output logic          FRAME_START
);

    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CLK_HIGH = (CLK_DIV + 1) / 2;
    localparam int unsigned DL       = (PIPE_DELAY > 0) ? PIPE_DELAY : 1;
    // Delay-line word is {hsync, vsync, blank_n}; idle is both syncs inactive, blanked.
    localparam logic [2:0]  IDLE     = {~HS_POL, ~VS_POL, 1'b0};

    logic [DIV_W-1:0] div_q, div_d;
    logic             vga_clk_q, vga_clk_d;
    logic [2:0]       dly_q [DL];
    logic [2:0]       dly_d [DL];
    logic [2:0]       out_q, out_d;
    logic [2:0]       raw, dly_tail;
    logic             div_last;
    logic             h_wrap, h_act, h_sync_rgn;
    logic             v_wrap, v_act, v_sync_rgn;

    // RST gates the strobe so CLK_DIV=1 cannot tick while held in reset.
    assign div_last = 32'(div_q) == CLK_DIV - 1;
    assign PIX_EN   = EN && RST && div_last;

    video_axis_counter #(
        .ACTIVE_LEN(H_ACTIVE), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC_LEN),
        .BACK_LEN(H_BACK), .CW(CW)
    ) u_h (
        .clk(CLK), .rst_n(RST), .step(PIX_EN), .pos(SCREEN_POS_X),
        .wrap(h_wrap), .active(h_act), .in_sync(h_sync_rgn)
    );

    video_axis_counter #(
        .ACTIVE_LEN(V_ACTIVE), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC_LEN),
        .BACK_LEN(V_BACK), .CW(CW)
    ) u_v (
        .clk(CLK), .rst_n(RST), .step(h_wrap), .pos(SCREEN_POS_Y),
        .wrap(v_wrap), .active(v_act), .in_sync(v_sync_rgn)
    );

    assign ACTIVE      = h_act && v_act;
    assign LINE_START  = h_wrap;
    assign FRAME_START = v_wrap;
    assign raw         = {h_sync_rgn ? HS_POL : ~HS_POL, v_sync_rgn ? VS_POL : ~VS_POL, ACTIVE};
    assign dly_tail    = (PIPE_DELAY == 0) ? raw : dly_q[DL-1];

    always_comb begin
        div_d     = div_q;
        vga_clk_d = vga_clk_q;
        dly_d     = dly_q;
        out_d     = out_q;
        if (EN) begin
            div_d     = div_last ? '0 : div_q + DIV_W'(1);
            vga_clk_d = 32'(div_d) < CLK_HIGH;
            out_d     = dly_tail;
        end
        if (PIX_EN) begin
            dly_d[0] = raw;
            for (int i = 1; i < DL; i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_q     <= '0;
            vga_clk_q <= 1'b0;
            out_q     <= IDLE;
            for (int i = 0; i < DL; i++) begin
                dly_q[i] <= IDLE;
            end
        end else begin
            div_q     <= div_d;
            vga_clk_q <= vga_clk_d;
            out_q     <= out_d;
            dly_q     <= dly_d;
        end
    end

    assign H_SYNC      = out_q[2];
    assign V_SYNC      = out_q[1];
    assign VGA_BLANK_N = out_q[0];
    assign VGA_CLK     = vga_clk_q;
    assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: four parameterisations share clock, reset and enable;
// a tick-count raster model checks every output each cycle, with directed literal checks.
module tb_vga_timing_generator;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b1;
    int   ecnt  = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic [9:0] d_x, d_y;
    logic d_pix, d_act, d_hs, d_vs, d_bn, d_sn, d_vclk, d_ls, d_fs;
    logic [3:0] s0_x, s0_y;
    logic s0_pix, s0_act, s0_hs, s0_vs, s0_bn, s0_sn, s0_vclk, s0_ls, s0_fs;
    logic [3:0] s3_x, s3_y;
    logic s3_pix, s3_act, s3_hs, s3_vs, s3_bn, s3_sn, s3_vclk, s3_ls, s3_fs;
    logic [3:0] p_x, p_y;
    logic p_pix, p_act, p_hs, p_vs, p_bn, p_sn, p_vclk, p_ls, p_fs;

    vga_timing_generator u_def (
        .CLK(clk), .RST(rst_n), .EN(en), .SCREEN_POS_X(d_x), .SCREEN_POS_Y(d_y),
        .PIX_EN(d_pix), .ACTIVE(d_act), .H_SYNC(d_hs), .V_SYNC(d_vs), .VGA_BLANK_N(d_bn),
        .VGA_SYNC_N(d_sn), .VGA_CLK(d_vclk), .LINE_START(d_ls), .FRAME_START(d_fs)
    );

    vga_timing_generator #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC_LEN(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC_LEN(1), .V_BACK(1),
        .CLK_DIV(1), .PIPE_DELAY(0), .CW(4)
    ) u_s0 (
        .CLK(clk), .RST(rst_n), .EN(en), .SCREEN_POS_X(s0_x), .SCREEN_POS_Y(s0_y),
        .PIX_EN(s0_pix), .ACTIVE(s0_act), .H_SYNC(s0_hs), .V_SYNC(s0_vs), .VGA_BLANK_N(s0_bn),
        .VGA_SYNC_N(s0_sn), .VGA_CLK(s0_vclk), .LINE_START(s0_ls), .FRAME_START(s0_fs)
    );

    vga_timing_generator #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC_LEN(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC_LEN(1), .V_BACK(1),
        .CLK_DIV(1), .PIPE_DELAY(3), .CW(4)
    ) u_s3 (
        .CLK(clk), .RST(rst_n), .EN(en), .SCREEN_POS_X(s3_x), .SCREEN_POS_Y(s3_y),
        .PIX_EN(s3_pix), .ACTIVE(s3_act), .H_SYNC(s3_hs), .V_SYNC(s3_vs), .VGA_BLANK_N(s3_bn),
        .VGA_SYNC_N(s3_sn), .VGA_CLK(s3_vclk), .LINE_START(s3_ls), .FRAME_START(s3_fs)
    );

    vga_timing_generator #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC_LEN(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC_LEN(1), .V_BACK(1),
        .CLK_DIV(3), .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DELAY(1), .CW(4)
    ) u_sp (
        .CLK(clk), .RST(rst_n), .EN(en), .SCREEN_POS_X(p_x), .SCREEN_POS_Y(p_y),
        .PIX_EN(p_pix), .ACTIVE(p_act), .H_SYNC(p_hs), .V_SYNC(p_vs), .VGA_BLANK_N(p_bn),
        .VGA_SYNC_N(p_sn), .VGA_CLK(p_vclk), .LINE_START(p_ls), .FRAME_START(p_fs)
    );

    // Model state: number of enabled system clocks since the last reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else if (en) ecnt <= ecnt + 1;
    end

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Raster model: pixel index = enabled clocks / divider; outputs follow from arithmetic.
    task automatic chk_inst(input string nm, input int cd, input int ha, input int hf,
                            input int hs, input int hb, input int va, input int vf,
                            input int vs, input int vb, input int d, input bit hp, input bit vp,
                            input int ax, input int ay, input logic apix, input logic aact,
                            input logic ahs, input logic avs, input logic abn, input logic asn,
                            input logic avclk, input logic als, input logic afs);
        int ht, vt, t, x, y, k, kx, ky;
        logic epix, eact, ehs, evs, ebn, evclk, els, efs;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        t = ecnt / cd;
        x = t % ht;
        y = (t / ht) % vt;
        epix = rst_n && en && ((ecnt % cd) == cd - 1);
        eact = (x < ha) && (y < va);
        els = epix && (x == ht - 1);
        efs = els && (y == vt - 1);
        evclk = (ecnt == 0) ? 1'b0 : ((ecnt % cd) < (cd + 1) / 2);
        k = (ecnt == 0) ? -1 : ((ecnt - 1) / cd - d);
        if (k < 0) begin
            ehs = !hp; evs = !vp; ebn = 1'b0;
        end else begin
            kx = k % ht;
            ky = (k / ht) % vt;
            ehs = (kx >= ha + hf && kx < ha + hf + hs) ? hp : !hp;
            evs = (ky >= va + vf && ky < va + vf + vs) ? vp : !vp;
            ebn = (kx < ha) && (ky < va);
        end
        cmp({nm, ".x"}, ax, x);
        cmp({nm, ".y"}, ay, y);
        cmp({nm, ".pix_en"}, int'(apix), int'(epix));
        cmp({nm, ".active"}, int'(aact), int'(eact));
        cmp({nm, ".h_sync"}, int'(ahs), int'(ehs));
        cmp({nm, ".v_sync"}, int'(avs), int'(evs));
        cmp({nm, ".blank_n"}, int'(abn), int'(ebn));
        cmp({nm, ".sync_n"}, int'(asn), 0);
        cmp({nm, ".vga_clk"}, int'(avclk), int'(evclk));
        cmp({nm, ".line_start"}, int'(als), int'(els));
        cmp({nm, ".frame_start"}, int'(afs), int'(efs));
    endtask

    always @(posedge clk) begin
        #1;
        chk_inst("def", 2, 640, 16, 96, 48, 480, 10, 2, 33, 0, 1'b0, 1'b0,
                 int'(d_x), int'(d_y), d_pix, d_act, d_hs, d_vs, d_bn, d_sn, d_vclk, d_ls, d_fs);
        chk_inst("s0", 1, 4, 1, 2, 1, 3, 1, 1, 1, 0, 1'b0, 1'b0,
                 int'(s0_x), int'(s0_y), s0_pix, s0_act, s0_hs, s0_vs, s0_bn, s0_sn, s0_vclk, s0_ls, s0_fs);
        chk_inst("s3", 1, 4, 1, 2, 1, 3, 1, 1, 1, 3, 1'b0, 1'b0,
                 int'(s3_x), int'(s3_y), s3_pix, s3_act, s3_hs, s3_vs, s3_bn, s3_sn, s3_vclk, s3_ls, s3_fs);
        chk_inst("sp", 3, 4, 1, 2, 1, 3, 1, 1, 1, 1, 1'b1, 1'b1,
                 int'(p_x), int'(p_y), p_pix, p_act, p_hs, p_vs, p_bn, p_sn, p_vclk, p_ls, p_fs);
    end

    task automatic wait_s0(input int tx, input int ty, input string nm);
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #1;
            if (int'(s0_x) == tx && (ty < 0 || int'(s0_y) == ty)) found = 1'b1;
        end
        cmp({nm, ".reached"}, int'(found), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_hs, n_vs, n_bn, n_fs, n_ls;
        // Reset held with EN high: everything idle, PIX_EN gated even for CLK_DIV=1.
        repeat (3) @(negedge clk);
        cmp("rst.def_hs", int'(d_hs), 1);
        cmp("rst.def_vs", int'(d_vs), 1);
        cmp("rst.def_blank", int'(d_bn), 0);
        cmp("rst.def_vclk", int'(d_vclk), 0);
        cmp("rst.s0_pix", int'(s0_pix), 0);
        cmp("rst.sp_hs", int'(p_hs), 0);
        cmp("rst.sp_vs", int'(p_vs), 0);
        rst_n = 1'b1;

        // Default mode, CLK_DIV=2: strobe after the first edge, X=1 after the second.
        @(posedge clk); #1;
        cmp("first.def_pix", int'(d_pix), 1);
        cmp("first.def_x", int'(d_x), 0);
        @(posedge clk); #1;
        cmp("second.def_x", int'(d_x), 1);
        cmp("second.def_pix", int'(d_pix), 0);

        // One full small frame (48 ticks) of periodic statistics.
        repeat (10) @(posedge clk);
        n_hs = 0; n_vs = 0; n_bn = 0; n_fs = 0; n_ls = 0;
        for (int i = 0; i < 48; i++) begin
            @(posedge clk); #1;
            if (!s0_hs) n_hs++;
            if (!s0_vs) n_vs++;
            if (s0_bn) n_bn++;
            if (s0_fs) n_fs++;
            if (s0_ls) n_ls++;
        end
        cmp("frame.hsync_low", n_hs, 12);
        cmp("frame.vsync_low", n_vs, 8);
        cmp("frame.blank_high", n_bn, 12);
        cmp("frame.frame_start", n_fs, 1);
        cmp("frame.line_start", n_ls, 6);

        // PIPE_DELAY=3: falling edge of H_SYNC lands one edge after 3 ticks past X=5.
        wait_s0(5, -1, "dly.x5");
        repeat (3) @(posedge clk);
        #1 cmp("dly.hs_before", int'(s3_hs), 1);
        @(posedge clk); #1;
        cmp("dly.hs_fall", int'(s3_hs), 0);

        // Enable pause at (2,1): counters hold for 10 CLKs, then resume at X=3.
        wait_s0(2, 1, "en.x2y1");
        @(negedge clk); en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        cmp("en.hold_x", int'(s0_x), 2);
        cmp("en.hold_y", int'(s0_y), 1);
        cmp("en.hold_pix", int'(s0_pix), 0);
        @(negedge clk); en = 1'b1;
        @(posedge clk); #1;
        cmp("en.resume_x", int'(s0_x), 3);

        // Asynchronous reset mid-frame at (6,4).
        wait_s0(6, 4, "rst.x6y4");
        @(negedge clk); rst_n = 1'b0;
        #1;
        cmp("midrst.x", int'(s0_x), 0);
        cmp("midrst.y", int'(s0_y), 0);
        cmp("midrst.hs", int'(s0_hs), 1);
        cmp("midrst.vs", int'(s0_vs), 1);
        cmp("midrst.blank", int'(s0_bn), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cmp("midrst.restart_x", int'(s0_x), 1);
        repeat (100) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
